// File: rtl/rect_table_scheduler.sv
// rtl/rect_table_scheduler.sv - rectangle shadow/active table with round-robin writers and vblank commit
module rect_table_scheduler #(
  parameter int NUM_RECTS   = 14,
  parameter int VACTIVE     = 480,
  parameter int INIT_FIGURE = 1
) (
  input  logic                    vgaclk,
  input  logic                    reset,
  input  logic [9:0]              hcnt,
  input  logic [9:0]              vcnt,
  input  logic                    req0_valid,
  input  logic [3:0]              req0_idx,
  input  logic [39:0]             req0_rect,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [3:0]              req1_idx,
  input  logic [39:0]             req1_rect,
  output logic                    req1_ready,
  input  logic                    commit_req,
  output logic                    commit_pending,
  output logic                    frame_tick,
  output logic                    swap_done,
  output logic                    idx_err,
  output logic [NUM_RECTS*40-1:0] rects_flat
);

  localparam logic [9:0] VBS_LINE    = 10'(VACTIVE);
  localparam logic [4:0] NUM_RECTS_W = 5'(NUM_RECTS);

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  // Entry contents after reset: the stick figure, or all zero.
  function automatic logic [39:0] init_rect(input int i);
    logic [39:0] r;
    r = '0;
    if (INIT_FIGURE == 1) begin
      case (i)
        0:       r = {10'd300, 10'd340, 10'd100, 10'd140};
        1:       r = {10'd310, 10'd330, 10'd140, 10'd220};
        2:       r = {10'd270, 10'd310, 10'd150, 10'd170};
        3:       r = {10'd330, 10'd370, 10'd150, 10'd170};
        4:       r = {10'd310, 10'd320, 10'd220, 10'd300};
        5:       r = {10'd320, 10'd330, 10'd220, 10'd300};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic        rr_last_q, rr_last_d;
  logic        frame_tick_q, swap_done_q, swap_done_d;
  logic        idx_err_q, idx_err_d;
  logic [39:0] shadow_q [NUM_RECTS];
  logic [39:0] shadow_d [NUM_RECTS];
  logic [39:0] active_q [NUM_RECTS];
  logic [39:0] active_d [NUM_RECTS];

  logic        vbs;
  logic        grant0, grant1, wr_en, idx_ok, swap;
  logic [3:0]  wr_idx;
  logic [39:0] wr_data;

  assign vbs = (vcnt == VBS_LINE) && (hcnt == 10'd0);

  // Round-robin grant; rr_last_q=1 means requester 1 was served last, so 0 wins a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!vbs) begin
      grant0 = req0_valid && (!req1_valid || rr_last_q);
      grant1 = req1_valid && (!req0_valid || !rr_last_q);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign wr_en      = grant0 | grant1;
  assign wr_idx     = grant1 ? req1_idx  : req0_idx;
  assign wr_data    = grant1 ? req1_rect : req0_rect;
  assign idx_ok     = {1'b0, wr_idx} < NUM_RECTS_W;

  // Commit FSM: a request waits in PENDING until the next blanking start.
  always_comb begin
    state_d = state_q;
    swap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (commit_req) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (vbs) begin
          swap    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Table next-state: granted write into shadow, full shadow copy into active on swap.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en && idx_ok) shadow_d[wr_idx] = wr_data;
    if (swap) active_d = shadow_q;
    idx_err_d   = idx_err_q | (wr_en && !idx_ok);
    rr_last_d   = grant0 ? 1'b0 : (grant1 ? 1'b1 : rr_last_q);
    swap_done_d = swap;
  end

  // State registers; reset restores the default tables and drops any pending commit.
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= 1'b1;
      frame_tick_q <= 1'b0;
      swap_done_q  <= 1'b0;
      idx_err_q    <= 1'b0;
      for (int i = 0; i < NUM_RECTS; i++) begin
        shadow_q[i] <= init_rect(i);
        active_q[i] <= init_rect(i);
      end
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      frame_tick_q <= vbs;
      swap_done_q  <= swap_done_d;
      idx_err_q    <= idx_err_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  assign commit_pending = (state_q == ST_PENDING);
  assign frame_tick     = frame_tick_q;
  assign swap_done      = swap_done_q;
  assign idx_err        = idx_err_q;

  for (genvar g = 0; g < NUM_RECTS; g++) begin : g_flat
    assign rects_flat[g*40 +: 40] = active_q[g];
  end

endmodule

// File: tb/tb_rect_table_scheduler.sv
// tb/tb_rect_table_scheduler.sv - self-checking bench for rect_table_scheduler
module tb_rect_table_scheduler;

  localparam int N = 14;

  logic          vgaclk = 1'b0;
  logic          reset;
  logic [9:0]    hcnt, vcnt;
  logic          req0_valid, req1_valid;
  logic [3:0]    req0_idx, req1_idx;
  logic [39:0]   req0_rect, req1_rect;
  logic          req0_ready, req1_ready;
  logic          commit_req;
  logic          commit_pending, frame_tick, swap_done, idx_err;
  logic [N*40-1:0] rects_flat;

  rect_table_scheduler #(.NUM_RECTS(N), .VACTIVE(480), .INIT_FIGURE(1)) dut (
    .vgaclk(vgaclk), .reset(reset), .hcnt(hcnt), .vcnt(vcnt),
    .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_rect(req0_rect), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_rect(req1_rect), .req1_ready(req1_ready),
    .commit_req(commit_req), .commit_pending(commit_pending), .frame_tick(frame_tick),
    .swap_done(swap_done), .idx_err(idx_err), .rects_flat(rects_flat)
  );

  always #5 vgaclk = ~vgaclk;

  typedef struct {
    logic v0;
    logic v1;
    logic vbs;
    logic r0;
    logic r1;
  } vec_t;

  vec_t        vecs [13];
  logic [1:0]  sb [$];
  logic [39:0] m_shadow [N];
  logic [39:0] m_active [N];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [39:0] def_rect(input int i);
    case (i)
      0:       return {10'd300, 10'd340, 10'd100, 10'd140};
      1:       return {10'd310, 10'd330, 10'd140, 10'd220};
      2:       return {10'd270, 10'd310, 10'd150, 10'd170};
      3:       return {10'd330, 10'd370, 10'd150, 10'd170};
      4:       return {10'd310, 10'd320, 10'd220, 10'd300};
      5:       return {10'd320, 10'd330, 10'd220, 10'd300};
      default: return 40'd0;
    endcase
  endfunction

  function automatic logic [39:0] dut_rect(input int i);
    return rects_flat[i*40 +: 40];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_table(input string name);
    for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", name, i), 64'(dut_rect(i)), 64'(m_active[i]));
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = def_rect(i);
      m_active[i] = def_rect(i);
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0; req1_valid = 1'b0; commit_req = 1'b0;
    req0_idx = 4'd0; req1_idx = 4'd0; req0_rect = '0; req1_rect = '0;
    vcnt = 10'd100; hcnt = 10'd5;
  endtask

  task automatic set_vbs(input logic on);
    vcnt = on ? 10'd480 : 10'd100;
    hcnt = on ? 10'd0 : 10'd5;
  endtask

  task automatic cyc();
    @(posedge vgaclk); #1;
  endtask

  task automatic drv();
    @(negedge vgaclk);
  endtask

  initial begin
    // {v0, v1, vbs, expected ready0, expected ready1}; rr starts with requester 0 favoured
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    idle();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge vgaclk);
    drv();
    reset = 1'b0;
    #1;

    chk("reset_rect0", 64'(dut_rect(0)), 64'({10'd300, 10'd340, 10'd100, 10'd140}));
    chk("reset_rect6", 64'(dut_rect(6)), 64'd0);
    chk("reset_ready0", 64'(req0_ready), 64'd0);
    chk("reset_ready1", 64'(req1_ready), 64'd0);
    chk("reset_pending", 64'(commit_pending), 64'd0);
    chk("reset_idx_err", 64'(idx_err), 64'd0);
    chk("reset_swap_done", 64'(swap_done), 64'd0);

    // Arbitration table, scoreboard of expected grants
    for (int i = 0; i < 13; i++) begin
      logic [1:0] exp_g;
      req0_valid = vecs[i].v0;
      req1_valid = vecs[i].v1;
      req0_idx   = 4'(i % N);
      req1_idx   = 4'((i + 7) % N);
      req0_rect  = {10'(i), 10'(i + 100), 10'(i + 200), 10'(i + 300)};
      req1_rect  = {10'(i + 500), 10'(i + 600), 10'(i + 700), 10'(i + 800)};
      set_vbs(vecs[i].vbs);
      sb.push_back({vecs[i].r0, vecs[i].r1});
      if (vecs[i].r0) m_shadow[i % N] = req0_rect;
      if (vecs[i].r1) m_shadow[(i + 7) % N] = req1_rect;
      #1;
      exp_g = sb.pop_front();
      chk($sformatf("arb%0d_ready0", i), 64'(req0_ready), 64'(exp_g[1]));
      chk($sformatf("arb%0d_ready1", i), 64'(req1_ready), 64'(exp_g[0]));
      cyc();
      chk($sformatf("arb%0d_frame_tick", i), 64'(frame_tick), 64'(vecs[i].vbs));
      chk($sformatf("arb%0d_swap_done", i), 64'(swap_done), 64'd0);
      drv();
    end

    // Publish the arbitrated writes
    idle();
    commit_req = 1'b1;
    cyc();
    chk("arb_commit_pending", 64'(commit_pending), 64'd1);
    drv();
    idle();
    chk_table("arb_before_swap");
    set_vbs(1'b1);
    cyc();
    for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
    chk("arb_swap_done", 64'(swap_done), 64'd1);
    chk("arb_pending_clear", 64'(commit_pending), 64'd0);
    chk_table("arb_after_swap");
    drv();
    idle();
    cyc();
    chk("arb_swap_done_pulse", 64'(swap_done), 64'd0);
    chk("arb_frame_tick_pulse", 64'(frame_tick), 64'd0);
    drv();

    // Write idx 7 via req0, commit, blanking start
    req0_valid = 1'b1; req0_idx = 4'd7; req0_rect = {10'd10, 10'd20, 10'd30, 10'd40};
    #1;
    chk("w7_ready0", 64'(req0_ready), 64'd1);
    m_shadow[7] = {10'd10, 10'd20, 10'd30, 10'd40};
    cyc();
    drv();
    idle();
    commit_req = 1'b1;
    cyc();
    chk("w7_pending", 64'(commit_pending), 64'd1);
    chk("w7_rect7_before", 64'(dut_rect(7)), 64'(m_active[7]));
    drv();
    idle();
    set_vbs(1'b1);
    #1;
    chk("w7_rect7_at_vbs", 64'(dut_rect(7)), 64'(m_active[7]));
    cyc();
    m_active[7] = m_shadow[7];
    chk("w7_rect7_after", 64'(dut_rect(7)), 64'({10'd10, 10'd20, 10'd30, 10'd40}));
    chk("w7_swap_done", 64'(swap_done), 64'd1);
    chk("w7_pending_clear", 64'(commit_pending), 64'd0);
    chk("w7_frame_tick", 64'(frame_tick), 64'd1);
    drv();
    idle();
    cyc();
    chk("w7_swap_done_once", 64'(swap_done), 64'd0);
    drv();

    // Out-of-range index from req1
    req1_valid = 1'b1; req1_idx = 4'd14; req1_rect = {10'd1, 10'd1, 10'd1, 10'd1};
    #1;
    chk("oor_ready1", 64'(req1_ready), 64'd1);
    cyc();
    chk("oor_idx_err", 64'(idx_err), 64'd1);
    drv();
    idle();
    commit_req = 1'b1;
    cyc();
    drv();
    idle();
    set_vbs(1'b1);
    cyc();
    chk("oor_swap_done", 64'(swap_done), 64'd1);
    chk_table("oor_table");
    chk("oor_idx_err_sticky", 64'(idx_err), 64'd1);
    drv();

    // commit_req on a blanking-start cycle while idle
    idle();
    req0_valid = 1'b1; req0_idx = 4'd8; req0_rect = {10'd1, 10'd2, 10'd3, 10'd4};
    m_shadow[8] = req0_rect;
    cyc();
    drv();
    idle();
    set_vbs(1'b1);
    commit_req = 1'b1;
    cyc();
    chk("cvbs_pending", 64'(commit_pending), 64'd1);
    chk("cvbs_no_swap", 64'(swap_done), 64'd0);
    chk("cvbs_rect8_old", 64'(dut_rect(8)), 64'(m_active[8]));
    drv();
    idle();
    repeat (3) begin cyc(); drv(); end
    chk("cvbs_still_pending", 64'(commit_pending), 64'd1);
    set_vbs(1'b1);
    cyc();
    m_active[8] = m_shadow[8];
    chk("cvbs_swap_done", 64'(swap_done), 64'd1);
    chk("cvbs_rect8_new", 64'(dut_rect(8)), 64'({10'd1, 10'd2, 10'd3, 10'd4}));
    chk("cvbs_pending_clear", 64'(commit_pending), 64'd0);
    drv();

    // Reset while a commit is pending
    idle();
    commit_req = 1'b1;
    cyc();
    chk("rst_pending_set", 64'(commit_pending), 64'd1);
    drv();
    idle();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_pending", 64'(commit_pending), 64'd0);
    chk("rst_idx_err", 64'(idx_err), 64'd0);
    chk_table("rst_table");
    drv();
    reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_rr_ready0", 64'(req0_ready), 64'd1);
    chk("rst_rr_ready1", 64'(req1_ready), 64'd0);
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rect_table_scheduler.md
Name: rect_table_scheduler

Overview:
- Owns the rectangle table that drives the VGA pixel-generation path.
- Arbitrates rectangle-update writes from two requesters into a shadow table, using round-robin and a valid/ready handshake. Requester 0 is the sensor/host side; requester 1 is the animation engine.
- Copies shadow to active only at the start of vertical blanking, and only when a commit is pending, so a visible frame never shows a half-updated figure.
- The active table feeds the rectangle hit-test logic directly.

Parameters:
- NUM_RECTS, 14: number of table entries; index width is 4 bits.
- VACTIVE, 480: visible line count; the blanking-start line.
- INIT_FIGURE, 1: 1 = reset loads the default stick figure into entries 0-5; 0 = all entries zero.

Ports:
- vgaclk  in  1  pixel clock; all state is on its rising edge.
- reset  in  1  asynchronous, active-high.
- hcnt  in  10  current horizontal pixel count from the timing generator.
- vcnt  in  10  current line count from the timing generator.
- req0_valid  in  1  requester 0 write request.
- req0_idx  in  4  requester 0 entry index.
- req0_rect  in  40  requester 0 data, packed {left[39:30], right[29:20], top[19:10], bot[9:0]}.
- req0_ready  out  1  requester 0 write accepted this cycle.
- req1_valid, req1_idx, req1_rect, req1_ready: same as requester 0, for requester 1.
- commit_req  in  1  single-cycle pulse: publish the shadow table at the next blanking start.
- commit_pending  out  1  a commit is waiting for blanking start.
- frame_tick  out  1  one-cycle pulse at every blanking start.
- swap_done  out  1  one-cycle pulse when active was loaded from shadow.
- idx_err  out  1  sticky flag: an out-of-range index was accepted.
- rects_flat  out  NUM_RECTS*40  active table; entry i at [i*40+39 : i*40]; registered.

Behaviour:
- Blanking start (vbs) is the cycle where vcnt==VACTIVE and hcnt==0. It is evaluated combinationally from the inputs.
- Reset values:
  - Shadow and active tables both load the default figure when INIT_FIGURE=1.
  - Default figure (left,right,top,bot):
    - entry 0: (300,340,100,140)
    - entry 1: (310,330,140,220)
    - entry 2: (270,310,150,170)
    - entry 3: (330,370,150,170)
    - entry 4: (310,320,220,300)
    - entry 5: (320,330,220,300)
    - entries 6-13: all zero.
  - commit_pending=0, frame_tick=0, swap_done=0, idx_err=0, rr_last=1 (requester 0 has priority first), both ready=0.
- Arbitration:
  - At most one write per cycle.
  - readyN is combinational: asserted only for the granted valid requester.
  - If only one requester is valid, it is granted.
  - If both are valid, the one not granted last is granted. rr_last updates on each grant.
  - No grant on a vbs cycle: both readys are 0 and the shadow is stable while it is copied.
- Write:
  - A grant in cycle N writes the shadow entry, which is visible in the shadow at N+1.
  - Index >= NUM_RECTS: the handshake completes, no entry changes, idx_err sets. idx_err clears only on reset.
  - Data is stored unmodified; no left<right or top<bot checking.
- Commit FSM, two states:
  - IDLE: commit_req moves to PENDING.
  - PENDING: on vbs, active is loaded from the full shadow, swap_done pulses at N+1, and the state returns to IDLE.
  - commit_req while PENDING is absorbed with no effect.
  - commit_req on a vbs cycle while IDLE sets PENDING only. The swap happens at the following frame's vbs, not the current one.
  - commit_pending = (state == PENDING).
- frame_tick is registered: it is high on cycle N+1 for a vbs at cycle N, whether or not a swap occurs.
- Shadow writes never alter rects_flat until a swap.
- Reset mid-frame or mid-handshake returns all state to the reset values immediately. Any pending commit is lost.

Test Plan:
- Reset release, no stimulus → rects_flat entry 0 = {300,340,100,140}, entry 6 = 0; readys low; commit_pending=0; idx_err=0.
- Write idx 7 = (10,20,30,40) via req0, pulse commit_req, step vcnt to 480 with hcnt=0 → rects_flat entry 7 unchanged before vbs and equal to (10,20,30,40) the cycle after; swap_done one pulse; commit_pending 1→0.
- req0 and req1 held valid together for 4 cycles → grants alternate 0,1,0,1; each write lands in the shadow the following cycle.
- Both requesters valid on a vbs cycle → both readys 0 that cycle; the grant resumes the next cycle; frame_tick pulses once.
- req1 writes idx 14 → handshake completes, no entry changes, idx_err=1 and it stays set through later commits.
- commit_req on the vbs cycle from IDLE → no swap that frame; commit_pending=1 until the next vbs; swap occurs then. Reset asserted while PENDING → commit_pending=0 and the default figure is restored.
